// File: rtl/romem_arbiter_pkg.sv
// Shared types and helpers for the instruction-memory read arbiter.
package romem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait
   } state_e;

   localparam int unsigned DefaultTimeout = 8;

   // Width of an encoded requester id; never narrower than one bit.
   function automatic int unsigned id_width(input int unsigned n_req);
      return (n_req > 1) ? $clog2(n_req) : 1;
   endfunction

endpackage

// File: rtl/romem_arbiter_if.sv
// Requester and memory-side signal bundle of the read arbiter.
interface romem_arbiter_if #(
   parameter int unsigned N_REQ        = 2,
   parameter int unsigned WORD_SIZE    = 32,
   parameter int unsigned ADDRESS_SIZE = 16
);

   logic [N_REQ-1:0]              req_i;
   logic [N_REQ*ADDRESS_SIZE-1:0] addr_i;
   logic [N_REQ-1:0]              gnt_o;
   logic [N_REQ-1:0]              rvalid_o;
   logic                          rerr_o;
   logic [WORD_SIZE-1:0]          rdata_o;
   logic                          busy_o;
   logic                          mem_enable_o;
   logic [ADDRESS_SIZE-1:0]       mem_address_o;
   logic [WORD_SIZE-1:0]          mem_data_i;
   logic                          mem_data_ready_i;

   modport slave (
      input  req_i, addr_i, mem_data_i, mem_data_ready_i,
      output gnt_o, rvalid_o, rerr_o, rdata_o, busy_o, mem_enable_o, mem_address_o
   );

   modport master (
      output req_i, addr_i, mem_data_i, mem_data_ready_i,
      input  gnt_o, rvalid_o, rerr_o, rdata_o, busy_o, mem_enable_o, mem_address_o
   );

endinterface

// File: rtl/romem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_picker
   import romem_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned IdW   = id_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IdW-1:0]   ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IdW-1:0]   id
);

   int unsigned idx;
   logic        found;

   always_comb begin
      gnt   = '0;
      id    = '0;
      found = 1'b0;
      idx   = 0;
      // ptr itself is visited last, so the requester just served has lowest priority.
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         idx = (32'(ptr) + k) % N_REQ;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            id       = IdW'(idx);
         end
      end
   end

endmodule

// File: rtl/romem_arbiter.sv
// Round-robin arbiter sharing a read-only memory with registered DATA_READY
// between N_REQ requesters; aborts an access after TIMEOUT WAIT cycles.
module romem_arbiter
   import romem_arb_pkg::*;
#(
   parameter int unsigned N_REQ        = 2,
   parameter int unsigned WORD_SIZE    = 32,
   parameter int unsigned ADDRESS_SIZE = 16,
   parameter int unsigned TIMEOUT      = DefaultTimeout
) (
   input logic            clk,
   input logic            rst,
   romem_arbiter_if.slave bus
);

   localparam int unsigned     IdW     = id_width(N_REQ);
   localparam int unsigned     CntW    = $clog2(TIMEOUT);
   localparam logic [IdW-1:0]  PtrRst  = IdW'(N_REQ - 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   state_e                  state_q, state_d;
   logic [IdW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [IdW-1:0]          id_q, id_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
   logic [WORD_SIZE-1:0]    rdata_q, rdata_d;
   logic [N_REQ-1:0]        rvalid_q, rvalid_d;
   logic                    rerr_q, rerr_d;

   logic [N_REQ-1:0]        pick_gnt;
   logic [IdW-1:0]          pick_id;
   logic                    any_req;
   logic [N_REQ-1:0]        done_onehot;
   logic [ADDRESS_SIZE-1:0] req_addr [N_REQ];

   for (genvar k = 0; k < N_REQ; k++) begin : g_addr
      assign req_addr[k] = bus.addr_i[k*ADDRESS_SIZE +: ADDRESS_SIZE];
   end

   assign any_req     = |bus.req_i;
   assign done_onehot = N_REQ'(1'b1) << id_q;

   rr_picker #(
      .N_REQ (N_REQ),
      .IdW   (IdW)
   ) u_rr_picker (
      .req (bus.req_i),
      .ptr (rr_ptr_q),
      .gnt (pick_gnt),
      .id  (pick_id)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         rr_ptr_q <= PtrRst;
         id_q     <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= '0;
         rerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         rerr_q   <= rerr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      rdata_d  = rdata_q;
      rvalid_d = '0;
      rerr_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               state_d  = StIssue;
               rr_ptr_d = pick_id;
               id_d     = pick_id;
               cnt_d    = '0;
               addr_d   = req_addr[pick_id];
            end
         end
         // DATA_READY may still be high from the previous access; not looked at here.
         StIssue: state_d = StWait;
         StWait: begin
            cnt_d = cnt_q + 1'b1;
            if (bus.mem_data_ready_i) begin
               rdata_d  = bus.mem_data_i;
               rvalid_d = done_onehot;
               state_d  = StIdle;
            end else if (cnt_q == CntLast) begin
               rdata_d  = '0;
               rvalid_d = done_onehot;
               rerr_d   = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.gnt_o        = '0;
      bus.busy_o       = 1'b0;
      bus.mem_enable_o = 1'b0;
      unique case (state_q)
         StIdle: bus.gnt_o = pick_gnt;
         StIssue, StWait: begin
            bus.busy_o       = 1'b1;
            bus.mem_enable_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.rvalid_o      = rvalid_q;
   assign bus.rerr_o        = rerr_q;
   assign bus.rdata_o       = rdata_q;
   assign bus.mem_address_o = addr_q;

endmodule
